// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive FIFO placed directly after the UART receiver.
//   First-word-fall-through read port. Provides level, threshold and
//   sticky overrun status.
// Optional feature macro: UART_RX_FIFO_PERR_TAG_EN. When it is defined,
//   each entry carries a parity-error tag bit.
// Ports:
//   pclk, presetn         clock, async active-low reset
//   rx_wr, rx_data        character write from receiver
//   rx_full_status        FIFO full (receiver write gating)
//   rx_rd, rx_rdata       pop strobe, head entry (0 while empty)
//   rx_empty, rx_level    empty flag, occupancy 0..DEPTH
//   rx_thr, rx_thr_hit    threshold (0 = off), registered level>=thr
//   fifo_clr              synchronous flush of both pointers
//   overrun_err, ovr_clr  sticky write-while-full flag and its clear
//   s_parrity_error, rx_rdata_perr   (only with UART_RX_FIFO_PERR_TAG_EN)
module uart_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              rx_wr,
  input  logic [DATA_W-1:0] rx_data,
  output logic              rx_full_status,
  input  logic              rx_rd,
  output logic [DATA_W-1:0] rx_rdata,
  output logic              rx_empty,
  output logic [ADDR_W:0]   rx_level,
  input  logic [ADDR_W:0]   rx_thr,
  output logic              rx_thr_hit,
  input  logic              fifo_clr,
  output logic              overrun_err,
`ifdef UART_RX_FIFO_PERR_TAG_EN
  input  logic              s_parrity_error,
  output logic              rx_rdata_perr,
`endif
  input  logic              ovr_clr
);

  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]   r_wptr, r_rptr;
  logic              r_thr_hit, r_ovr;
  logic              w_empty, w_full, w_wr_ok, w_rd_ok, w_ovr_set;
  logic [ADDR_W-1:0] w_widx, w_ridx;

  assign w_widx  = r_wptr[ADDR_W-1:0];
  assign w_ridx  = r_rptr[ADDR_W-1:0];
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (w_widx == w_ridx) && (r_wptr[ADDR_W] != r_rptr[ADDR_W]);

  // Full is judged on the pre-read state, so write+read while full drops
  // the write. Flush overrides both strobes.
  assign w_wr_ok   = rx_wr && !w_full && !fifo_clr;
  assign w_rd_ok   = rx_rd && !w_empty && !fifo_clr;
  assign w_ovr_set = rx_wr && w_full && !fifo_clr;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (fifo_clr) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr_ok) r_wptr <= r_wptr + PTR_ONE;
      if (w_rd_ok) r_rptr <= r_rptr + PTR_ONE;
    end
  end

  // Storage is deliberately not reset; rx_rdata is masked while empty.
  always_ff @(posedge pclk) begin
    if (w_wr_ok) r_mem[w_widx] <= rx_data;
  end

  // Threshold flag samples the current level, so it trails a level
  // change by one edge. Overrun set has priority over clear.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_thr_hit <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_thr_hit <= (rx_thr != '0) && (rx_level >= rx_thr);
      if (w_ovr_set)    r_ovr <= 1'b1;
      else if (ovr_clr) r_ovr <= 1'b0;
    end
  end

  assign rx_level       = r_wptr - r_rptr;
  assign rx_empty       = w_empty;
  assign rx_full_status = w_full;
  assign rx_rdata       = w_empty ? '0 : r_mem[w_ridx];
  assign rx_thr_hit     = r_thr_hit;
  assign overrun_err    = r_ovr;

`ifdef UART_RX_FIFO_PERR_TAG_EN
  // Pending flag: a parity pulse marks the next write attempt. Any write
  // attempt (accepted or dropped) consumes it; the pulse arriving in the
  // same cycle as the write is included in that write's tag.
  logic [DEPTH-1:0] r_tag;
  logic             r_pend;
  logic             w_pend;

  assign w_pend = r_pend || s_parrity_error;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn)      r_pend <= 1'b0;
    else if (fifo_clr) r_pend <= 1'b0;
    else if (rx_wr)    r_pend <= 1'b0;
    else               r_pend <= w_pend;
  end

  always_ff @(posedge pclk) begin
    if (w_wr_ok) r_tag[w_widx] <= w_pend;
  end

  assign rx_rdata_perr = w_empty ? 1'b0 : r_tag[w_ridx];
`endif

endmodule
